// File: rtl/vga_score_overlay_if.sv
// ============================================================================
// vga_score_overlay_if : register-write bus for the score overlay
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_score_overlay_if;
  logic        chipselect;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;

  modport master (output chipselect, output write, output address, output writedata);
  modport slave  (input  chipselect, input  write, input  address, input  writedata);
endinterface

`default_nettype wire

// File: rtl/vga_score_overlay.sv
// ============================================================================
// vga_score_overlay : BCD score register, per-frame shadow, scaled 5x7 digits
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_score_overlay #(
  parameter int DIGITS     = 3,
  parameter int SCALE_LOG2 = 1,
  parameter int GAP        = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vga_score_overlay_if.slave    bus,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  input  logic                  frame_start,
  input  logic                  score_inc,
  output logic                  pix_on,
  output logic [23:0]           pix_rgb,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  overflow
);

  localparam int SW     = 4 * DIGITS;
  localparam int CW     = (5 + GAP) << SCALE_LOG2;
  localparam int GH     = 7 << SCALE_LOG2;
  localparam int TW     = DIGITS * CW;
  localparam int CELL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic          en_q, wrap_q, blank_q;
  logic [9:0]    pos_x_q, pos_y_q;
  logic [23:0]   fg_q;
  logic [SW-1:0] score_q, score_d, shadow_q;
  logic          ovf_q, ovf_d;

  logic              s1_hit_q, s1_gap_q;
  logic [CELL_W-1:0] s1_cell_q;
  logic [2:0]        s1_col_q, s1_row_q;
  logic [3:0]        s1_digit_q;
  logic              pix_on_q;
  logic [23:0]       pix_rgb_q;

  logic wr_w, clear_w, load_w;
  assign wr_w    = bus.chipselect & bus.write;
  assign clear_w = wr_w && (bus.address == 3'd0) && bus.writedata[1];
  assign load_w  = wr_w && (bus.address == 3'd3);

  logic [8:0] unused_bits;
  assign unused_bits = {hcount[0], bus.writedata[31:24]};

  // Score next-state; carry out of the ripple means every digit was 9.
  logic [SW-1:0] inc_w, load_val_w;
  logic          carry_w;
  always_comb begin
    inc_w      = score_q;
    load_val_w = '0;
    carry_w    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry_w) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          inc_w[4*i +: 4] = 4'd0;
        end else begin
          inc_w[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry_w = 1'b0;
        end
      end
      load_val_w[4*i +: 4] = (bus.writedata[4*i +: 4] > 4'd9) ? 4'd9 : bus.writedata[4*i +: 4];
    end
    score_d = score_q;
    ovf_d   = ovf_q;
    if (clear_w) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (load_w) begin
      score_d = load_val_w;
      ovf_d   = 1'b0;
    end else if (score_inc) begin
      if (carry_w) begin
        ovf_d   = 1'b1;
        score_d = wrap_q ? '0 : score_q;
      end else begin
        score_d = inc_w;
      end
    end
  end

  // Leading-zero mask indexed by cell position (cell 0 = MS digit).
  logic [DIGITS-1:0] lz_cell_w;
  logic              nz_w;
  always_comb begin
    lz_cell_w = '0;
    nz_w      = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz_w = nz_w | (shadow_q[4*i +: 4] != 4'd0);
      lz_cell_w[DIGITS-1-i] = blank_q & ~nz_w;
    end
  end

  // Stage-1 geometry: cell found by a compare chain against constant offsets.
  logic [15:0]       x_w, y_w, px_w, py_w, dx_w, dy_w, off_w;
  logic              hit_w, gap_w;
  logic [CELL_W-1:0] cell_w;
  logic [3:0]        digit_w;
  logic [2:0]        col_w, row_w;
  always_comb begin
    x_w   = {6'd0, hcount[10:1]};
    y_w   = {6'd0, vcount};
    px_w  = {6'd0, pos_x_q};
    py_w  = {6'd0, pos_y_q};
    dx_w  = x_w - px_w;
    dy_w  = y_w - py_w;
    hit_w = en_q && (x_w >= px_w) && (dx_w < 16'(TW)) && (y_w >= py_w) && (dy_w < 16'(GH));
    cell_w  = '0;
    off_w   = dx_w;
    digit_w = shadow_q[SW-1 -: 4];
    for (int k = 1; k < DIGITS; k++) begin
      if (dx_w >= 16'(k * CW)) begin
        cell_w  = CELL_W'(k);
        off_w   = dx_w - 16'(k * CW);
        digit_w = shadow_q[4*(DIGITS-1-k) +: 4];
      end
    end
    gap_w = (off_w >> SCALE_LOG2) >= 16'd5;
    col_w = 3'(off_w >> SCALE_LOG2);
    row_w = 3'(dy_w >> SCALE_LOG2);
  end

  function automatic logic [4:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
    logic [34:0] g;
    case (d)
      4'd0: g = 35'b01110_10001_10011_10101_11001_10001_01110;
      4'd1: g = 35'b00100_01100_00100_00100_00100_00100_01110;
      4'd2: g = 35'b01110_10001_00001_00010_00100_01000_11111;
      4'd3: g = 35'b11111_00010_00100_00010_00001_10001_01110;
      4'd4: g = 35'b00010_00110_01010_10010_11111_00010_00010;
      4'd5: g = 35'b11111_10000_11110_00001_00001_10001_01110;
      4'd6: g = 35'b00110_01000_10000_11110_10001_10001_01110;
      4'd7: g = 35'b11111_00001_00010_00100_01000_01000_01000;
      4'd8: g = 35'b01110_10001_10001_01110_10001_10001_01110;
      4'd9: g = 35'b01110_10001_10001_01111_00001_00010_01100;
      default: g = '0;
    endcase
    glyph_row = g[34 - 5*r -: 5];
  endfunction

  logic [4:0] glyph_w;
  logic       on_w;
  always_comb begin
    glyph_w = glyph_row(s1_digit_q, s1_row_q);
    on_w    = s1_hit_q & ~s1_gap_q & ~lz_cell_w[s1_cell_q] & glyph_w[3'd4 - s1_col_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q       <= 1'b1;
      wrap_q     <= 1'b0;
      blank_q    <= 1'b0;
      pos_x_q    <= 10'd10;
      pos_y_q    <= 10'd10;
      fg_q       <= 24'hFFFFFF;
      score_q    <= '0;
      shadow_q   <= '0;
      ovf_q      <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_gap_q   <= 1'b0;
      s1_cell_q  <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_digit_q <= '0;
      pix_on_q   <= 1'b0;
      pix_rgb_q  <= '0;
    end else begin
      if (wr_w) begin
        case (bus.address)
          3'd0: begin
            en_q    <= bus.writedata[0];
            wrap_q  <= bus.writedata[2];
            blank_q <= bus.writedata[3];
          end
          3'd1: pos_x_q <= bus.writedata[9:0];
          3'd2: pos_y_q <= bus.writedata[9:0];
          3'd4: fg_q    <= bus.writedata[23:0];
          default: ;
        endcase
      end
      score_q <= score_d;
      ovf_q   <= ovf_d;
      if (frame_start) shadow_q <= score_d;
      s1_hit_q   <= hit_w;
      s1_gap_q   <= gap_w;
      s1_cell_q  <= cell_w;
      s1_col_q   <= col_w;
      s1_row_q   <= row_w;
      s1_digit_q <= digit_w;
      pix_on_q   <= on_w;
      pix_rgb_q  <= on_w ? fg_q : 24'd0;
    end
  end

  assign pix_on    = pix_on_q;
  assign pix_rgb   = pix_rgb_q;
  assign score_bcd = score_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire
